// File: rtl/alu_pkg.sv
// Shared definitions for the streaming ALU: opcode encodings, flag bit
// positions and the sequencing FSM state type.
package alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_CLR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_MUL  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NAND = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NOT  = 4'b1101;
   localparam logic [3:0] OP_SHL  = 4'b1110;
   localparam logic [3:0] OP_SHR  = 4'b1111;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH iterations, done pulses for one cycle with the full product held.
module mul_shift_add #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   prod_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;

   // Upper half accumulates; the multiplier sits in the lower half and is
   // consumed LSB-first as the whole register shifts right.
   always_comb begin
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      if (start_i) begin
         mcand_d = a_i;
         prod_d  = {{WIDTH{1'b0}}, b_i};
         cnt_d   = CW'(WIDTH);
         busy_d  = 1'b1;
      end else if (busy_q) begin
         prod_d = {sum, prod_q[WIDTH-1:1]};
         cnt_d  = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign prod_o = prod_q;

endmodule

// File: rtl/alu_stream.sv
// Registered streaming ALU with valid/ready on both sides; single-cycle ops
// plus an iterative multiply that holds off new operands while it runs.
//
// state | meaning
// IDLE  | accepting operands; single-cycle results load the output register
// MUL   | multiplier running; result loads when it signals done
module alu_stream
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             out_err
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;

   logic             accept;
   logic             mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_x, sub_x, shl_x, shr_x;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_err;

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (r == '0);
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign in_ready  = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (opcode == OP_MUL);

   mul_shift_add #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mul_start),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   // The extra top bit of each wide result is the carry/borrow or the last
   // bit shifted out; for SHR it lands below the result instead.
   assign shamt = b[SHW-1:0];
   assign add_x = {1'b0, a} + {1'b0, b};
   assign sub_x = {1'b0, a} - {1'b0, b};
   assign shl_x = {1'b0, a} << shamt;
   assign shr_x = {a, 1'b0} >> shamt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (opcode)
         OP_NOP, OP_CLR, OP_MUL: alu_res = '0;
         OP_ADD: begin
            alu_res = add_x[WIDTH-1:0];
            alu_c   = add_x[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_x[WIDTH-1:0];
            alu_c   = sub_x[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NAND: alu_res = ~(a & b);
         OP_NOR:  alu_res = ~(a | b);
         OP_NOT:  alu_res = ~a;
         OP_SHL: begin
            alu_res = shl_x[WIDTH-1:0];
            alu_c   = shl_x[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_x[WIDTH:1];
            alu_c   = shr_x[0];
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      err_d       = err_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  state_d = MUL;
               end else if (opcode != OP_NOP) begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  flags_d     = mk_flags(alu_res, alu_c, alu_v);
                  err_d       = alu_err;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               result_d    = mul_prod[WIDTH-1:0];
               flags_d     = mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
               err_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_alu_stream.sv
// Directed and randomized checks of alu_stream at WIDTH=16 against an
// arithmetic reference model of the opcode/flag rules.
module tb_alu_stream;
   import alu_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a, b;
   logic [3:0]    opcode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [3:0]    flags;
   logic          out_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_stream #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .out_err   (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Returns {err, V, C, N, Z, result[15:0]}
   function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      int unsigned    r;
      bit             c, v, e;
      int             sx, sy, s, sh;
      longint unsigned p;
      r  = 0; c = 0; v = 0; e = 0;
      sx = int'($signed(x));
      sy = int'($signed(y));
      sh = int'(y[3:0]);
      case (op)
         4'h0, 4'h1: r = 0;
         4'h4: begin
            r = int'(x) + int'(y);
            c = (r > 65535);
            r = r & 32'hFFFF;
            s = sx + sy;
            v = (s > 32767) || (s < -32768);
         end
         4'h5: begin
            r = (int'(x) - int'(y)) & 32'hFFFF;
            c = (x < y);
            s = sx - sy;
            v = (s > 32767) || (s < -32768);
         end
         4'h6: begin
            p = longint'(x) * longint'(y);
            r = int'(p & 64'hFFFF);
            c = ((p >> 16) != 0);
         end
         4'h8: r = int'(x & y);
         4'h9: r = int'(x | y);
         4'hA: r = int'(x ^ y);
         4'hB: r = (~(int'(x) & int'(y))) & 32'hFFFF;
         4'hC: r = (~(int'(x) | int'(y))) & 32'hFFFF;
         4'hD: r = (~int'(x)) & 32'hFFFF;
         4'hE: begin
            r = (int'(x) << sh) & 32'hFFFF;
            c = (sh != 0) && (((int'(x) >> (16 - sh)) & 1) != 0);
         end
         4'hF: begin
            r = int'(x) >> sh;
            c = (sh != 0) && (((int'(x) >> (sh - 1)) & 1) != 0);
         end
         default: begin
            r = 0;
            e = 1;
         end
      endcase
      return {e, v, c, r[15], (r == 0), r[15:0]};
   endfunction

   // Issues one op with out_ready=1 and checks the result at its expected edge.
   task automatic do_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      logic [20:0] e;
      int          n;
      e = model(op, x, y);
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = op;
      a        = x;
      b        = y;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      opcode   = 4'($urandom);
      if (op == OP_MUL) begin
         for (int i = 0; i <= W; i++) begin
            chk("mul_wait_valid", out_valid, 0);
            chk("mul_wait_ready", in_ready, 0);
            @(posedge clk);
            #1;
         end
      end
      if (op == OP_NOP) begin
         chk("nop_no_valid", out_valid, 0);
      end else begin
         chk("valid", out_valid, 1);
         chk("result", result, e[15:0]);
         chk("flags", flags, e[19:16]);
         chk("err", out_err, e[20]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      opcode    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_err", out_err, 0);
      chk("rst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      do_op(OP_ADD, 16'h7FFF, 16'h0001);
      chk("add_ovf_res", result, 16'h8000);
      chk("add_ovf_flags", flags, 4'b1010);
      do_op(OP_SUB, 16'h0003, 16'h0005);
      chk("sub_borrow_res", result, 16'hFFFE);
      chk("sub_borrow_flags", flags, 4'b0110);
      do_op(OP_ADD, 16'hFFFF, 16'h0001);
      chk("add_carry_res", result, 16'h0000);
      chk("add_carry_flags", flags, 4'b0101);
      do_op(OP_MUL, 16'h0100, 16'h0100);
      chk("mul_hi_res", result, 16'h0000);
      chk("mul_hi_flags", flags, 4'b0101);
      do_op(OP_MUL, 16'h0012, 16'h0034);
      chk("mul_lo_res", result, 16'h03A8);
      chk("mul_lo_flags", flags, 4'b0000);

      // Backpressure: hold AND result, then drain and accept XOR together
      @(negedge clk);
      in_valid = 1'b1; opcode = OP_AND; a = 16'hF0F0; b = 16'hFF00;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      opcode = OP_XOR; a = 16'h00FF; b = 16'h0F0F;
      chk("bp_valid", out_valid, 1);
      chk("bp_res", result, 16'hF000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_res", result, 16'hF000);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_res", result, 16'h0FF0);

      // Reset during the 5th multiply cycle
      @(negedge clk);
      in_valid = 1'b1; opcode = OP_MUL; a = 16'h1234; b = 16'h5678;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midmul_rst_valid", out_valid, 0);
      chk("midmul_rst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      do_op(OP_ADD, 16'h0002, 16'h0003);
      chk("post_rst_add", result, 16'h0005);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("no_stale_mul", out_valid, 0);
      end

      do_op(4'b0010, 16'h1234, 16'h5678);
      chk("illegal_res", result, 16'h0000);
      chk("illegal_err", out_err, 1);
      chk("illegal_flags", flags, 4'b0001);
      @(posedge clk);
      #1;
      do_op(OP_NOP, 16'hAAAA, 16'h5555);
      @(posedge clk);
      #1;
      chk("nop_still_idle", out_valid, 0);
      do_op(OP_SHL, 16'h8001, 16'h0001);
      chk("shl_res", result, 16'h0002);
      chk("shl_flags", flags, 4'b0100);

      for (int i = 0; i < 60; i++) begin
         do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
